// File: rtl/ram_burst_reader.sv
// Burst reader: streams len words from a synchronous RAM starting at base_addr_i.
// Ports: clk_i/rst_i, start_i/base_addr_i/len_i request, ram_* read port, data_o/valid_o/ready_i/last_o stream, busy_o/done_o status.
module ram_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
  output logic                  ram_rd_o,
  output logic                  ram_output_reg_en_o,
  input  logic [DATA_WIDTH-1:0] ram_rd_data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int DEPTH = RD_LATENCY + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int LW    = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] nxt_q, nxt_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [LW-1:0]         rd_rem_q, rd_rem_d;
  logic [LW-1:0]         beats_q, beats_d;
  logic [RD_LATENCY-1:0] pipe_q, pipe_d;
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  logic       push, pop, issue;
  logic [2:0] inflight, occ;

  always_comb begin
    push     = pipe_q[RD_LATENCY-1];
    pop      = valid_o && ready_i;
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + {2'b00, pipe_q[i]};
    end
    // A beat leaving this cycle frees its slot, so a read can issue
    // every cycle while the sink keeps up.
    occ   = inflight + cnt_q - {2'b00, pop};
    issue = (state_q == READ) && (occ < 3'(DEPTH));

    state_d  = state_q;
    nxt_d    = nxt_q;
    last_d   = last_q;
    rd_rem_d = rd_rem_q;
    beats_d  = pop ? beats_q - LW'(1) : beats_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          nxt_d    = base_addr_i;
          rd_rem_d = len_i;
          beats_d  = len_i;
          state_d  = (len_i == '0) ? DRAIN : READ;
        end
      end
      READ: begin
        if (issue) begin
          nxt_d    = nxt_q + ADDR_WIDTH'(1);
          last_d   = nxt_q;
          rd_rem_d = rd_rem_q - LW'(1);
          if (rd_rem_q == LW'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (beats_q == '0 || (pop && beats_q == LW'(1))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Read-valid shift line: the top bit marks data arriving this cycle.
    pipe_d = RD_LATENCY'({pipe_q, issue});

    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      mem_d[wptr_q] = ram_rd_data_i;
      wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
    end
    cnt_d = cnt_q + {2'b00, push} - {2'b00, pop};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      nxt_q    <= '0;
      last_q   <= '0;
      rd_rem_q <= '0;
      beats_q  <= '0;
      pipe_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      nxt_q    <= nxt_d;
      last_q   <= last_d;
      rd_rem_q <= rd_rem_d;
      beats_q  <= beats_d;
      pipe_q   <= pipe_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign ram_rd_o            = issue;
  // Address only moves while a read is issued; otherwise shows the last one.
  assign ram_rd_addr_o       = issue ? nxt_q : last_q;
  assign ram_output_reg_en_o = 1'b1;
  assign valid_o             = (cnt_q != '0);
  assign data_o              = valid_o ? mem_q[rptr_q] : '0;
  assign last_o              = valid_o && (beats_q == LW'(1));
  assign busy_o              = (state_q != IDLE);
  assign done_o              = done_q;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: RD_LATENCY 1 and 2 instances side by side,
// scoreboards for addresses and beats, per-scenario tasks.
module tb_ram_burst_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       ready = 1'b1;
  logic [4:0] base = '0;
  logic [5:0] len = '0;

  logic [4:0] rd_addr [2];
  logic       rd [2];
  logic       oreg [2];
  logic [7:0] data [2];
  logic       valid [2];
  logic       last [2];
  logic       busy [2];
  logic       done [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rd_cnt [2];
  int done_cnt [2];
  int done_cyc [2];

  logic [8:0] sbq [2][$];
  logic [4:0] aq  [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] m1, m2, rdata, pd;
    logic       st, pl;
    logic [4:0] ea;
    logic [8:0] eb;

    ram_burst_reader #(
      .DATA_WIDTH(8), .ADDR_WIDTH(5), .RD_LATENCY(g + 1)
    ) u_dut (
      .clk_i(clk), .rst_i(rst), .start_i(start),
      .base_addr_i(base), .len_i(len),
      .ram_rd_addr_o(rd_addr[g]), .ram_rd_o(rd[g]),
      .ram_output_reg_en_o(oreg[g]), .ram_rd_data_i(rdata),
      .data_o(data[g]), .valid_o(valid[g]), .ready_i(ready),
      .last_o(last[g]), .busy_o(busy[g]), .done_o(done[g])
    );

    // RAM model: mem[a] = a + 8'h40, optional output register.
    always @(posedge clk) begin
      if (rd[g]) m1 <= {3'b000, rd_addr[g]} + 8'h40;
      if (oreg[g]) m2 <= m1;
    end
    assign rdata = (g == 0) ? m1 : m2;

    always @(negedge clk) begin
      if (rst) begin
        st = 1'b0;
      end else begin
        if (rd[g]) begin
          rd_cnt[g]++;
          n_checks++;
          if (aq[g].size() == 0) begin
            n_fail++;
            $display("FAIL rd_extra lat%0d: read addr %0d issued, none expected", g + 1, rd_addr[g]);
          end else begin
            ea = aq[g].pop_front();
            if (rd_addr[g] !== ea) begin
              n_fail++;
              $display("FAIL rd_addr lat%0d: got %0d want %0d", g + 1, rd_addr[g], ea);
            end
          end
        end
        if (st) begin
          n_checks++;
          if (valid[g] !== 1'b1 || data[g] !== pd || last[g] !== pl) begin
            n_fail++;
            $display("FAIL stall_hold lat%0d: got v%b d%h l%b want v1 d%h l%b", g + 1, valid[g], data[g], last[g], pd, pl);
          end
        end
        if (valid[g] && ready) begin
          n_checks++;
          if (sbq[g].size() == 0) begin
            n_fail++;
            $display("FAIL beat_extra lat%0d: got d%h l%b, no beat expected", g + 1, data[g], last[g]);
          end else begin
            eb = sbq[g].pop_front();
            if ({last[g], data[g]} !== eb) begin
              n_fail++;
              $display("FAIL beat lat%0d: got l%b d%h want l%b d%h", g + 1, last[g], data[g], eb[8], eb[7:0]);
            end
          end
        end
        st = valid[g] && !ready;
        pd = data[g];
        pl = last[g];
        if (done[g]) begin
          done_cnt[g]++;
          done_cyc[g] = cyc;
        end
      end
    end
  end

  task automatic expect_burst(input logic [4:0] b, input int l);
    logic [4:0] a;
    for (int i = 0; i < l; i++) begin
      a = 5'(b + 5'(i));
      for (int g = 0; g < 2; g++) begin
        sbq[g].push_back({(i == l - 1), 8'h40 + {3'b000, a}});
        aq[g].push_back(a);
      end
    end
  endtask

  task automatic start_burst(input logic [4:0] b, input int l);
    expect_burst(b, l);
    base  = b;
    len   = 6'(l);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy[0] && !busy[1] && sbq[0].size() == 0 && sbq[1].size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL timeout %s: got busy %b%b beats left %0d/%0d want idle, 0/0", tag, busy[0], busy[1], sbq[0].size(), sbq[1].size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      n_checks++;
      if ({valid[g], last[g], busy[g], done[g], rd[g], rd_addr[g], data[g]} !== 18'd0 || oreg[g] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset lat%0d: got v%b l%b b%b d%b rd%b a%0d d%h oreg%b want zeros oreg1", g + 1, valid[g], last[g], busy[g], done[g], rd[g], rd_addr[g], data[g], oreg[g]);
      end
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic ev, el, ed, eb;
    ready = 1'b1;
    start_burst(5'd3, 4);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        ev = (k >= g + 3) && (k <= g + 6);
        el = (k == g + 6);
        ed = (k == g + 7);
        eb = (k <= g + 6);
        n_checks++;
        if ({valid[g], last[g], done[g], busy[g]} !== {ev, el, ed, eb}) begin
          n_fail++;
          $display("FAIL basic_timing lat%0d k%0d: got vldb %b%b%b%b want %b%b%b%b", g + 1, k, valid[g], last[g], done[g], busy[g], ev, el, ed, eb);
        end
      end
    end
    @(posedge clk);
    #1;
    wait_idle("basic");
  endtask

  task automatic test_wrap();
    ready = 1'b1;
    start_burst(5'd30, 4);
    wait_idle("wrap");
  endtask

  task automatic test_len0();
    int d0 [2];
    ready = 1'b1;
    d0 = done_cnt;
    start_burst(5'd5, 0);
    base  = 5'd9;
    len   = 6'd3;
    start = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      n_checks++;
      if ({busy[g], done[g], valid[g]} !== 3'b100) begin
        n_fail++;
        $display("FAIL len0_busy lat%0d: got bdv %b%b%b want 100", g + 1, busy[g], done[g], valid[g]);
      end
    end
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      n_checks++;
      if ({busy[g], done[g], valid[g]} !== 3'b010) begin
        n_fail++;
        $display("FAIL len0_done lat%0d: got bdv %b%b%b want 010", g + 1, busy[g], done[g], valid[g]);
      end
    end
    @(posedge clk);
    #1;
    wait_idle("len0");
    for (int g = 0; g < 2; g++) begin
      n_checks++;
      if (done_cnt[g] !== d0[g] + 1) begin
        n_fail++;
        $display("FAIL len0_done_count lat%0d: got %0d want %0d", g + 1, done_cnt[g] - d0[g], 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    ready = 1'b1;
    expect_burst(5'd4, 2);
    expect_burst(5'd20, 3);
    base  = 5'd4;
    len   = 6'd2;
    start = 1'b1;
    @(posedge clk);
    #1 c0 = cyc;
    base = 5'd20;
    len  = 6'd3;
    repeat (6) @(posedge clk);
    #1 start = 1'b0;
    wait_idle("b2b");
    for (int g = 0; g < 2; g++) begin
      n_checks++;
      if (done_cyc[g] !== c0 + 2 * g + 10) begin
        n_fail++;
        $display("FAIL b2b_done_cycle lat%0d: got %0d want %0d", g + 1, done_cyc[g] - c0, 2 * g + 10);
      end
    end
  endtask

  task automatic test_random_stall();
    bit ok = 1'b0;
    int d0 [2];
    d0 = done_cnt;
    ready = 1'b1;
    start_burst(5'($urandom_range(0, 31)), 32);
    for (int i = 0; i < 400; i++) begin
      ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!busy[0] && !busy[1] && sbq[0].size() == 0 && sbq[1].size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    ready = 1'b1;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL timeout random: got beats left %0d/%0d want 0/0", sbq[0].size(), sbq[1].size());
    end
    wait_idle("random");
    for (int g = 0; g < 2; g++) begin
      n_checks++;
      if (done_cnt[g] !== d0[g] + 1) begin
        n_fail++;
        $display("FAIL random_done_count lat%0d: got %0d want 1", g + 1, done_cnt[g] - d0[g]);
      end
    end
  endtask

  task automatic test_reset_mid();
    ready     = 1'b0;
    rd_cnt[0] = 0;
    rd_cnt[1] = 0;
    start_burst(5'd0, 32);
    repeat (8) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      n_checks++;
      if (rd_cnt[g] !== g + 2 || valid[g] !== 1'b1 || rd[g] !== 1'b0) begin
        n_fail++;
        $display("FAIL fifo_fill lat%0d: got reads %0d v%b rd%b want reads %0d v1 rd0", g + 1, rd_cnt[g], valid[g], rd[g], g + 2);
      end
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) begin
      n_checks++;
      if ({valid[g], last[g], busy[g], done[g], rd[g], rd_addr[g], data[g]} !== 18'd0) begin
        n_fail++;
        $display("FAIL mid_reset lat%0d: got v%b l%b b%b d%b rd%b a%0d d%h want zeros", g + 1, valid[g], last[g], busy[g], done[g], rd[g], rd_addr[g], data[g]);
      end
      sbq[g].delete();
      aq[g].delete();
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      n_checks++;
      if (valid[g] !== 1'b0) begin
        n_fail++;
        $display("FAIL stale_beat lat%0d: got valid %b want 0", g + 1, valid[g]);
      end
    end
    start_burst(5'd0, 2);
    wait_idle("post_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_len0();
    test_back_to_back();
    test_random_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
